// File: rtl/grid_scan_ctrl.sv
// rtl/grid_scan_ctrl.sv - raster sweep sequencer for the HPIXELS x VPIXELS grid
// Optional macro BOUNDARY_FLAG_EN adds the registered boundary_out wall flag.
module grid_scan_ctrl #(
  parameter int HPIXELS = 205,
  parameter int VPIXELS = 154,
  parameter int CNT_W   = 16,
  localparam int HW = $clog2(HPIXELS),
  localparam int VW = $clog2(VPIXELS),
  localparam int AW = $clog2(HPIXELS * VPIXELS)
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic             abort_in,
  input  logic             ready_in,
  output logic             valid_out,
  output logic [HW-1:0]    hor_out,
  output logic [VW-1:0]    vert_out,
  output logic [AW-1:0]    addr_out,
  output logic             last_out,
  output logic             busy_out,
  output logic             done_out,
`ifdef BOUNDARY_FLAG_EN
  output logic             boundary_out,
`endif
  output logic [CNT_W-1:0] sweep_cnt_out
);

  localparam logic [HW-1:0] HMAX = HW'(HPIXELS - 1);
  localparam logic [VW-1:0] VMAX = VW'(VPIXELS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state;

  logic [HW-1:0] hor_nxt;
  logic [VW-1:0] vert_nxt;
  logic          last_nxt;

  always_comb begin
    hor_nxt  = hor_out + HW'(1);
    vert_nxt = vert_out;
    if (hor_out == HMAX) begin
      hor_nxt  = '0;
      vert_nxt = vert_out + VW'(1);
    end
    last_nxt = (hor_nxt == HMAX) && (vert_nxt == VMAX);
  end

  // addr tracks the raster position incrementally, so it always equals HPIXELS*vert + hor.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= IDLE;
      valid_out     <= 1'b0;
      hor_out       <= '0;
      vert_out      <= '0;
      addr_out      <= '0;
      last_out      <= 1'b0;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
      sweep_cnt_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_out <= 1'b0;
          if (start_in) begin
            state     <= SCAN;
            valid_out <= 1'b1;
            busy_out  <= 1'b1;
            hor_out   <= '0;
            vert_out  <= '0;
            addr_out  <= '0;
            last_out  <= 1'b0;
          end
        end
        SCAN: begin
          if (abort_in) begin
            state     <= IDLE;
            valid_out <= 1'b0;
            busy_out  <= 1'b0;
            hor_out   <= '0;
            vert_out  <= '0;
            addr_out  <= '0;
            last_out  <= 1'b0;
          end else if (ready_in) begin
            if (last_out) begin
              state         <= DONE;
              valid_out     <= 1'b0;
              done_out      <= 1'b1;
              sweep_cnt_out <= sweep_cnt_out + CNT_W'(1);
              hor_out       <= '0;
              vert_out      <= '0;
              addr_out      <= '0;
              last_out      <= 1'b0;
            end else begin
              hor_out  <= hor_nxt;
              vert_out <= vert_nxt;
              addr_out <= addr_out + AW'(1);
              last_out <= last_nxt;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          done_out <= 1'b0;
          busy_out <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          valid_out <= 1'b0;
          busy_out  <= 1'b0;
          done_out  <= 1'b0;
        end
      endcase
    end
  end

`ifdef BOUNDARY_FLAG_EN
  logic bnd_nxt;

  always_comb begin
    bnd_nxt = (hor_nxt == '0) || (hor_nxt == HMAX) || (vert_nxt == '0) || (vert_nxt == VMAX);
  end

  // Follows the same transitions as hor/vert; forced low whenever valid_out will be low.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      boundary_out <= 1'b0;
    end else if (state == IDLE) begin
      boundary_out <= start_in;
    end else if (state == SCAN) begin
      if (abort_in || (ready_in && last_out)) begin
        boundary_out <= 1'b0;
      end else if (ready_in) begin
        boundary_out <= bnd_nxt;
      end
    end else begin
      boundary_out <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_grid_scan_ctrl.sv
// tb/tb_grid_scan_ctrl.sv - scoreboard bench for grid_scan_ctrl (4x3 with CNT_W=2, plus default 205x154)
module tb_grid_scan_ctrl;
  localparam int H = 4;
  localparam int V = 3;
  localparam int BH = 205;
  localparam int BV = 154;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0, abort = 1'b0, ready = 1'b0;
  logic valid, last, busy, done;
  logic [1:0] hor, vert, cnt;
  logic [3:0] addr;
`ifdef BOUNDARY_FLAG_EN
  logic bnd, b_bnd;
`endif

  logic b_start = 1'b0, b_abort = 1'b0, b_ready = 1'b0;
  logic b_valid, b_last, b_busy, b_done;
  logic [7:0] b_hor, b_vert;
  logic [14:0] b_addr;
  logic [15:0] b_cnt;

  grid_scan_ctrl #(.HPIXELS(H), .VPIXELS(V), .CNT_W(2)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .abort_in(abort), .ready_in(ready),
    .valid_out(valid), .hor_out(hor), .vert_out(vert), .addr_out(addr), .last_out(last),
    .busy_out(busy), .done_out(done),
`ifdef BOUNDARY_FLAG_EN
    .boundary_out(bnd),
`endif
    .sweep_cnt_out(cnt)
  );

  grid_scan_ctrl dut_big (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(b_start), .abort_in(b_abort), .ready_in(b_ready),
    .valid_out(b_valid), .hor_out(b_hor), .vert_out(b_vert), .addr_out(b_addr), .last_out(b_last),
    .busy_out(b_busy), .done_out(b_done),
`ifdef BOUNDARY_FLAG_EN
    .boundary_out(b_bnd),
`endif
    .sweep_cnt_out(b_cnt)
  );

  typedef struct {
    int hor;
    int vert;
    int addr;
    bit last;
    bit bnd;
  } cell_t;

  cell_t exp_q[$];
  int    cnt_q[$];
  int    tests = 0;
  int    fails = 0;
  int    exp_cnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sweep();
    cell_t c;
    for (int v = 0; v < V; v++) begin
      for (int h = 0; h < H; h++) begin
        c.hor  = h;
        c.vert = v;
        c.addr = v * H + h;
        c.last = (h == H - 1) && (v == V - 1);
        c.bnd  = (h == 0) || (h == H - 1) || (v == 0) || (v == V - 1);
        exp_q.push_back(c);
      end
    end
  endtask

  task automatic run_full_sweep(input string name);
    cell_t c;
    int budget = 0;
    push_sweep();
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++;
    if (valid !== 1'b1) begin
      fails++;
      $display("FAIL %s start_latency: valid=%b required 1", name, valid);
    end
    while (exp_q.size() > 0 && budget < 50) begin
      c = exp_q.pop_front();
      tests++;
      if (valid !== 1'b1 || int'(hor) !== c.hor || int'(vert) !== c.vert ||
          int'(addr) !== c.addr || last !== c.last || done !== 1'b0) begin
        fails++;
        $display("FAIL %s cell: valid=%b hor=%0d vert=%0d addr=%0d last=%b done=%b required 1 %0d %0d %0d %b 0",
                 name, valid, hor, vert, addr, last, done, c.hor, c.vert, c.addr, c.last);
      end
`ifdef BOUNDARY_FLAG_EN
      tests++;
      if (bnd !== c.bnd) begin
        fails++;
        $display("FAIL %s boundary: addr=%0d boundary=%b required %b", name, c.addr, bnd, c.bnd);
      end
`endif
      tick();
      budget++;
    end
    exp_cnt = (exp_cnt + 1) % 4;
    tests++;
    if (done !== 1'b1 || valid !== 1'b0 || int'(cnt) !== exp_cnt || busy !== 1'b1) begin
      fails++;
      $display("FAIL %s done_cycle: done=%b valid=%b cnt=%0d busy=%b required 1 0 %0d 1",
               name, done, valid, cnt, busy, exp_cnt);
    end
    tick();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) begin
      fails++;
      $display("FAIL %s idle_after: done=%b busy=%b valid=%b required 0 0 0", name, done, busy, valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests++;
    if ({valid, hor, vert, addr, last, busy, done, cnt} !== 15'd0) begin
      fails++;
      $display("FAIL reset_small: valid=%b hor=%0d vert=%0d addr=%0d last=%b busy=%b done=%b cnt=%0d required all 0",
               valid, hor, vert, addr, last, busy, done, cnt);
    end
    tests++;
    if ({b_valid, b_addr, b_last, b_busy, b_done, b_cnt} !== 35'd0) begin
      fails++;
      $display("FAIL reset_big: valid=%b addr=%0d cnt=%0d required 0 0 0", b_valid, b_addr, b_cnt);
    end
`ifdef BOUNDARY_FLAG_EN
    tests++;
    if (bnd !== 1'b0) begin
      fails++;
      $display("FAIL reset_boundary: boundary=%b required 0", bnd);
    end
`endif
    #3;
    rst_n = 1'b1;
    tick();
    tick();
    tests++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: valid=%b busy=%b required 0 0", valid, busy);
    end
  endtask

  task automatic test_basic_sweep();
    run_full_sweep("basic");
  endtask

  task automatic test_backpressure();
    cell_t c;
    int budget = 0;
    bit r;
    push_sweep();
    ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (exp_q.size() > 0 && budget < 300) begin
      tests++;
      if (int'(addr) !== H * int'(vert) + int'(hor)) begin
        fails++;
        $display("FAIL bp_invariant: addr=%0d required %0d", addr, H * int'(vert) + int'(hor));
      end
      c = exp_q[0];
      tests++;
      if (valid !== 1'b1 || int'(hor) !== c.hor || int'(vert) !== c.vert ||
          int'(addr) !== c.addr || last !== c.last) begin
        fails++;
        $display("FAIL bp_cell: valid=%b hor=%0d vert=%0d addr=%0d last=%b required 1 %0d %0d %0d %b",
                 valid, hor, vert, addr, last, c.hor, c.vert, c.addr, c.last);
      end
      r = 1'($urandom_range(0, 1));
      ready = r;
      if (r) void'(exp_q.pop_front());
      tick();
      budget++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL bp_timeout: remaining=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    ready = 1'b1;
    exp_cnt = (exp_cnt + 1) % 4;
    tests++;
    if (done !== 1'b1 || int'(cnt) !== exp_cnt) begin
      fails++;
      $display("FAIL bp_done: done=%b cnt=%0d required 1 %0d", done, cnt, exp_cnt);
    end
    tick();
  endtask

  task automatic test_abort();
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      tests++;
      if (valid !== 1'b1 || int'(addr) !== i) begin
        fails++;
        $display("FAIL abort_pre: valid=%b addr=%0d required 1 %0d", valid, addr, i);
      end
      if (i == 5) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    tests++;
    if ({valid, hor, vert, addr, last, busy, done} !== 12'd0 || int'(cnt) !== exp_cnt) begin
      fails++;
      $display("FAIL abort_idle: valid=%b hor=%0d vert=%0d addr=%0d last=%b busy=%b done=%b cnt=%0d required zeros cnt=%0d",
               valid, hor, vert, addr, last, busy, done, cnt, exp_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (done !== 1'b0 || valid !== 1'b0) begin
        fails++;
        $display("FAIL abort_no_done: done=%b valid=%b required 0 0", done, valid);
      end
    end
    run_full_sweep("abort_restart");
  endtask

  task automatic test_ignored_starts_wrap();
    cell_t c;
    int budget = 0;
    int dones = 0;
    int cyc = 0;
    int last_done_cyc = 0;
    int e;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    exp_cnt = 0;
    for (int s = 0; s < 5; s++) push_sweep();
    cnt_q = '{1, 2, 3, 0, 1};
    ready = 1'b1;
    start = 1'b1;
    tick();
    while (dones < 5 && budget < 100) begin
      if (valid) begin
        c = exp_q.pop_front();
        tests++;
        if (int'(hor) !== c.hor || int'(vert) !== c.vert || int'(addr) !== c.addr) begin
          fails++;
          $display("FAIL wrap_cell: hor=%0d vert=%0d addr=%0d required %0d %0d %0d",
                   hor, vert, addr, c.hor, c.vert, c.addr);
        end
        if (c.addr == 0 && dones > 0) begin
          tests++;
          if (cyc - last_done_cyc != 2) begin
            fails++;
            $display("FAIL wrap_gap: gap=%0d required 2", cyc - last_done_cyc);
          end
        end
      end
      if (done) begin
        e = cnt_q.pop_front();
        tests++;
        if (int'(cnt) !== e || valid !== 1'b0) begin
          fails++;
          $display("FAIL wrap_cnt: cnt=%0d valid=%b required %0d 0", cnt, valid, e);
        end
        dones++;
        last_done_cyc = cyc;
        if (dones == 5) start = 1'b0;
      end
      tick();
      cyc++;
      budget++;
    end
    start = 1'b0;
    tests++;
    if (dones != 5 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL wrap_total: dones=%0d leftover=%0d required 5 0", dones, exp_q.size());
      exp_q.delete();
    end
    tick();
    tests++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL wrap_idle: valid=%b busy=%b required 0 0", valid, busy);
    end
  endtask

  task automatic test_async_reset();
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({valid, hor, vert, addr, last, busy, done, cnt} !== 15'd0) begin
      fails++;
      $display("FAIL async_reset: valid=%b hor=%0d vert=%0d addr=%0d last=%b busy=%b done=%b cnt=%0d required all 0",
               valid, hor, vert, addr, last, busy, done, cnt);
    end
    #7;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (done !== 1'b0 || valid !== 1'b0 || cnt !== 2'd0) begin
        fails++;
        $display("FAIL async_after: done=%b valid=%b cnt=%0d required 0 0 0", done, valid, cnt);
      end
    end
    exp_cnt = 0;
  endtask

  task automatic test_big_sweep();
    int h = 0, v = 0, a = 0;
    int last_addr = -1;
    int budget = 0;
    b_ready = 1'b1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    while (a < BH * BV && budget < 32000) begin
      tests++;
      if (b_valid !== 1'b1 || int'(b_hor) !== h || int'(b_vert) !== v || int'(b_addr) !== a ||
          b_last !== (a == BH * BV - 1) || int'(b_addr) !== BH * int'(b_vert) + int'(b_hor)) begin
        fails++;
        $display("FAIL big_cell: valid=%b hor=%0d vert=%0d addr=%0d last=%b required 1 %0d %0d %0d %b",
                 b_valid, b_hor, b_vert, b_addr, b_last, h, v, a, (a == BH * BV - 1));
      end
      if (b_last) last_addr = int'(b_addr);
      a++;
      h++;
      if (h == BH) begin
        h = 0;
        v++;
      end
      tick();
      budget++;
    end
    tests++;
    if (last_addr != 31569 || b_done !== 1'b1 || b_cnt !== 16'd1) begin
      fails++;
      $display("FAIL big_end: last_addr=%0d done=%b cnt=%0d required 31569 1 1", last_addr, b_done, b_cnt);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_sweep();
    test_backpressure();
    test_abort();
    test_ignored_starts_wrap();
    test_async_reset();
    test_big_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/grid_scan_ctrl.md
Name: grid_scan_ctrl

Overview:
Sequencer that sweeps every cell of the HPIXELS x VPIXELS simulation grid once per start command, in raster order. It presents (hor, vert, linear BRAM address) to a downstream consumer, such as the fluid update stage or the BRAM read port, over a valid/ready handshake. The linear address follows the grid address rule addr = HPIXELS*vert + hor. The block also reports sweep completion and keeps a sweep counter.

Parameters:
HPIXELS, 205, grid width in cells (>=2)
VPIXELS, 154, grid height in cells (>=2)
CNT_W, 16, width of sweep counter

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
start_in  input  1  begin one sweep; sampled only in IDLE
abort_in  input  1  terminate current sweep, no done pulse
ready_in  input  1  consumer accepts current cell
valid_out  output  1  current cell coordinates/address valid
hor_out  output  $clog2(HPIXELS)  column index
vert_out  output  $clog2(VPIXELS)  row index
addr_out  output  $clog2(HPIXELS*VPIXELS)  HPIXELS*vert_out + hor_out
last_out  output  1  current cell is (HPIXELS-1, VPIXELS-1)
busy_out  output  1  state != IDLE
done_out  output  1  one-cycle pulse after last cell accepted
sweep_cnt_out  output  CNT_W  completed sweeps, wraps

Behaviour:
- Reset (async, rst_n_in=0): state=IDLE; valid_out=0, hor/vert/addr=0, last_out=0, busy_out=0, done_out=0, sweep_cnt_out=0. Deassertion has no other effect. Reset mid-sweep abandons the sweep with no done pulse.
- States: IDLE, SCAN, DONE.
- IDLE:
  - valid_out=0.
  - start_in=1 -> SCAN next cycle, with hor=vert=addr=0 and valid_out=1. Latency start->valid is 1 cycle.
- SCAN:
  - valid_out=1. hor/vert/addr/last_out are registered and held stable while ready_in=0.
  - On valid_out & ready_in, advance one cell:
    - hor<HPIXELS-1: hor+1.
    - Otherwise hor=0, vert+1.
  - addr is kept incrementally (+1 per accepted cell); no multiplier in the datapath. The invariant addr_out == HPIXELS*vert_out + hor_out holds every cycle.
  - last_out is high exactly when hor=HPIXELS-1 and vert=VPIXELS-1.
  - Accept while last_out=1 -> DONE. valid_out drops the next cycle and sweep_cnt increments (wraps 2^CNT_W-1 -> 0).
  - abort_in=1 -> IDLE next cycle. Counters are cleared to 0, sweep_cnt is unchanged, and there is no done pulse. Abort has priority over a simultaneous accept.
  - start_in is ignored.
- DONE:
  - done_out=1, valid_out=0, for exactly one cycle, then IDLE.
  - start_in in DONE is ignored. A new sweep requires start_in in IDLE, so back-to-back sweeps have a 2-cycle gap (DONE, IDLE).
- Throughput: with ready_in held high, one cell per cycle; a full sweep takes HPIXELS*VPIXELS cycles in SCAN.
- No combinational path from ready_in or start_in to any output. All outputs are registered.

Optional Feature:
Macro BOUNDARY_FLAG_EN.
- Defined: adds output boundary_out (1 bit), registered alongside hor/vert. It is high when hor=0, hor=HPIXELS-1, vert=0, or vert=VPIXELS-1, and only while valid_out=1; otherwise 0. Reset value 0. Used by the consumer to apply wall conditions.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
(Use HPIXELS=4, VPIXELS=3 unless noted.)
- Basic sweep: reset, start pulse, ready_in=1 -> valid rises 1 cycle after start. Cells appear in order (0,0)..(3,2) with addr 0..11, one per cycle. last_out is high only at addr 11. done_out pulses once the cycle after the addr-11 accept. sweep_cnt_out goes 0->1 and busy_out then falls.
- Backpressure: toggle ready_in randomly -> outputs hold while ready_in=0. Each address 0..11 is emitted exactly once in order. addr_out == 4*vert_out + hor_out on every cycle.
- Abort: abort_in at addr 5 with ready_in=1 -> IDLE next cycle, outputs 0, no done_out, sweep_cnt unchanged. A subsequent start restarts at addr 0.
- Ignored starts and wrap: start_in held high through SCAN and DONE -> a single sweep per IDLE entry. With CNT_W=2, five sweeps give sweep_cnt sequence 1,2,3,0,1.
- Async reset: assert rst_n_in mid-sweep between clock edges -> all outputs are 0 immediately, no done pulse. Defaults HPIXELS=205, VPIXELS=154 full sweep ends at addr 31569.
- BOUNDARY_FLAG_EN defined: boundary_out is high for addrs {0,1,2,3,4,7,8,9,10,11} and low for {5,6}.
